// File: rtl/databus_arbiter_pkg.sv
// ============================================================================
// Module   : databus_pkg
// Brief    : Shared defaults, arbitration modes and bus state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package databus_pkg;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_CNT_W   = 8;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } bus_state_t;

endpackage : databus_pkg

`default_nettype wire

// File: rtl/databus_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin / fixed-priority request arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import databus_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int RR_MODE = ARB_RR,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   pointer,
  input  logic               enable,
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   index,
  output logic               any_grant
);

  int w_start;

  // Fixed priority is simply a search that always starts at index 0.
  assign w_start = (RR_MODE == ARB_RR) ? int'(pointer) : 0;

  always_comb begin
    int               j;
    logic [SEL_W-1:0] j_sel;
    grant     = '0;
    index     = '0;
    any_grant = 1'b0;
    j         = 0;
    j_sel     = '0;
    if (enable) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        j = w_start + k;
        if (j >= NUM_SRC) j = j - NUM_SRC;
        j_sel = SEL_W'(j);
        if (!any_grant && req[j_sel]) begin
          grant[j_sel] = 1'b1;
          index        = j_sel;
          any_grant    = 1'b1;
        end
      end
    end
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/databus_arbiter.sv
// ============================================================================
// Module   : databus_arbiter
// Brief    : Arbitrates source words onto a registered valid/ready databus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module databus_arbiter
  import databus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int RR_MODE = ARB_RR,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_grant,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic [DATA_W-1:0]         databus,
  output logic [SEL_W-1:0]          bus_src,
  output logic [CNT_W-1:0]          xfer_count
);

  bus_state_t          r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_data,  w_data_nxt;
  logic [SEL_W-1:0]    r_src,   w_src_nxt;
  logic [SEL_W-1:0]    r_ptr,   w_ptr_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;

  logic                w_load_en;
  logic                w_arb_en;
  logic                w_any;
  logic [SEL_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_words [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign w_words[gi] = src_data[gi*DATA_W +: DATA_W];
  end

  assign w_load_en = (r_state == ST_EMPTY) || bus_ready;
  // Grants are suppressed during reset so no source believes it was served.
  assign w_arb_en  = w_load_en && !rst;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .RR_MODE (RR_MODE),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req       (src_req),
    .pointer   (r_ptr),
    .enable    (w_arb_en),
    .grant     (src_grant),
    .index     (w_idx),
    .any_grant (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_src_nxt   = r_src;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    if ((r_state == ST_FULL) && bus_ready) w_count_nxt = r_count + CNT_W'(1);
    if (w_load_en) begin
      if (w_any) begin
        w_state_nxt = ST_FULL;
        w_data_nxt  = w_words[w_idx];
        w_src_nxt   = w_idx;
        if (RR_MODE == ARB_RR)
          w_ptr_nxt = (w_idx == SEL_W'(NUM_SRC-1)) ? '0 : w_idx + SEL_W'(1);
      end else begin
        w_state_nxt = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_src   <= w_src_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus_valid  = (r_state == ST_FULL);
  assign databus    = r_data;
  assign bus_src    = r_src;
  assign xfer_count = r_count;

endmodule : databus_arbiter

`default_nettype wire

// File: tb/tb_databus_arbiter.sv
// ============================================================================
// Module   : tb_databus_arbiter
// Brief    : Directed plus randomized bench for databus_arbiter (RR and fixed).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_databus_arbiter;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [15:0] data_a, data_b;
  logic        ready_a, ready_b;

  logic [3:0]  grant_a, grant_b;
  logic        valid_a, valid_b;
  logic [3:0]  bus_a, bus_b;
  logic [1:0]  src_a, src_b;
  logic [7:0]  count_a, count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  databus_arbiter #(.DATA_W(4), .NUM_SRC(4), .RR_MODE(1), .CNT_W(8)) dut_rr (
    .clk(clk), .rst(rst), .src_req(req_a), .src_data(data_a), .src_grant(grant_a),
    .bus_valid(valid_a), .bus_ready(ready_a), .databus(bus_a), .bus_src(src_a),
    .xfer_count(count_a)
  );

  databus_arbiter #(.DATA_W(4), .NUM_SRC(4), .RR_MODE(0), .CNT_W(8)) dut_fx (
    .clk(clk), .rst(rst), .src_req(req_b), .src_data(data_b), .src_grant(grant_b),
    .bus_valid(valid_b), .bus_ready(ready_b), .databus(bus_b), .bus_src(src_b),
    .xfer_count(count_b)
  );

  task automatic check(input string name, input int u, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d) at %0t: got %0h expected %0h", name, u, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the first requester found scanning from the start index.
  function automatic int pick(input bit rr, input logic [3:0] req, input int ptr);
    int start = rr ? ptr : 0;
    for (int k = 0; k < NS; k++) begin
      if (req[(start + k) % NS]) return (start + k) % NS;
    end
    return -1;
  endfunction

  bit         m_valid [2];
  logic [3:0] m_data  [2];
  int         m_src   [2];
  int         m_ptr   [2];
  int         m_count [2];

  logic [3:0]  c_req, c_grant, c_bus, c_eg;
  logic [15:0] c_dat;
  logic        c_rdy, c_valid;
  logic [1:0]  c_src;
  logic [7:0]  c_cnt;
  bit          c_load;
  int          c_win;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (u == 0) begin
        c_req = req_a; c_dat = data_a; c_rdy = ready_a;
        c_grant = grant_a; c_valid = valid_a; c_bus = bus_a; c_src = src_a; c_cnt = count_a;
      end else begin
        c_req = req_b; c_dat = data_b; c_rdy = ready_b;
        c_grant = grant_b; c_valid = valid_b; c_bus = bus_b; c_src = src_b; c_cnt = count_b;
      end
      if (rst) begin
        m_valid[u] = 1'b0; m_data[u] = 4'h0; m_src[u] = 0; m_ptr[u] = 0; m_count[u] = 0;
      end
      c_load = !m_valid[u] || c_rdy;
      c_win  = (rst || !c_load) ? -1 : pick(u == 0, c_req, m_ptr[u]);
      c_eg   = (c_win < 0) ? 4'b0000 : 4'(1 << c_win);
      check("model_grant", u, 32'(c_grant), 32'(c_eg));
      check("model_valid", u, 32'(c_valid), 32'(m_valid[u]));
      check("model_data",  u, 32'(c_bus),   32'(m_data[u]));
      check("model_src",   u, 32'(c_src),   m_src[u]);
      check("model_count", u, 32'(c_cnt),   m_count[u]);
      if (!rst) begin
        if (m_valid[u] && c_rdy) m_count[u] = (m_count[u] + 1) % 256;
        if (c_load) begin
          if (c_win >= 0) begin
            m_valid[u] = 1'b1;
            m_data[u]  = c_dat[c_win*4 +: 4];
            m_src[u]   = c_win;
            m_ptr[u]   = (c_win + 1) % NS;
          end else begin
            m_valid[u] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_a = 4'b1111; data_a = 16'h4321; ready_a = 1'b1;
    req_b = 4'b0000; data_b = 16'h0000; ready_b = 1'b1;

    repeat (3) begin
      step();
      check("rst_valid", 0, 32'(valid_a), 0);
      check("rst_grant", 0, 32'(grant_a), 0);
      check("rst_data",  0, 32'(bus_a),   0);
      check("rst_count", 0, 32'(count_a), 0);
    end
    rst = 1'b0;
    #1;
    check("first_grant", 0, 32'(grant_a), 32'h1);

    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_src",   0, 32'(src_a),   k % 4);
      check("rr_data",  0, 32'(bus_a),   (k % 4) + 1);
      check("rr_count", 0, 32'(count_a), k);
    end

    req_a = 4'b0100; data_a = 16'h0A00;
    #1;
    check("single_grant", 0, 32'(grant_a), 32'h4);
    step();
    check("single_valid", 0, 32'(valid_a), 1);
    check("single_data",  0, 32'(bus_a),   32'hA);
    check("single_src",   0, 32'(src_a),   2);

    req_a = 4'b0010; data_a = 16'h0050;
    step();
    check("bp_load_data",  0, 32'(bus_a),   5);
    check("bp_load_count", 0, 32'(count_a), 6);

    ready_a = 1'b0; req_a = 4'b0001; data_a = 16'h0007;
    #1;
    check("bp_grant", 0, 32'(grant_a), 0);
    repeat (3) begin
      step();
      check("bp_hold_data",  0, 32'(bus_a),   5);
      check("bp_hold_src",   0, 32'(src_a),   1);
      check("bp_hold_valid", 0, 32'(valid_a), 1);
      check("bp_hold_grant", 0, 32'(grant_a), 0);
      check("bp_hold_count", 0, 32'(count_a), 6);
    end
    ready_a = 1'b1;
    #1;
    check("bp_release_grant", 0, 32'(grant_a), 32'h1);
    step();
    check("bp_release_count", 0, 32'(count_a), 7);
    check("bp_release_data",  0, 32'(bus_a),   7);
    check("bp_release_src",   0, 32'(src_a),   0);

    req_a = 4'b1111; data_a = 16'h4321;
    repeat (248) step();
    check("count_at_max", 0, 32'(count_a), 255);
    step();
    check("count_wrap", 0, 32'(count_a), 0);
    repeat (255) step();
    check("count_max_again", 0, 32'(count_a), 255);
    check("full_before_rst", 0, 32'(valid_a), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 0, 32'(valid_a), 0);
    check("async_data",  0, 32'(bus_a),   0);
    check("async_src",   0, 32'(src_a),   0);
    check("async_count", 0, 32'(count_a), 0);
    check("async_grant", 0, 32'(grant_a), 0);
    step();
    rst = 1'b0;

    req_a = 4'b0000;
    req_b = 4'b1010; data_b = 16'h9030; ready_b = 1'b1;
    #1;
    check("fixed_grant0", 1, 32'(grant_b), 32'h2);
    repeat (4) begin
      step();
      check("fixed_src",   1, 32'(src_b),   1);
      check("fixed_data",  1, 32'(bus_b),   3);
      check("fixed_grant", 1, 32'(grant_b), 32'h2);
    end
    req_b = 4'b1000;
    #1;
    check("fixed_src3_grant", 1, 32'(grant_b), 32'h8);
    step();
    check("fixed_src3_src",  1, 32'(src_b), 3);
    check("fixed_src3_data", 1, 32'(bus_b), 9);

    repeat (3000) begin
      step();
      req_a   = 4'($urandom);
      data_a  = 16'($urandom);
      ready_a = ($urandom_range(0, 3) != 0);
      req_b   = 4'($urandom);
      data_b  = 16'($urandom);
      ready_b = ($urandom_range(0, 3) != 0);
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_databus_arbiter

`default_nettype wire
